// File: rtl/asic_ram_serializer.sv
// Transmit-side stand-in for the ASIC RAM readout link: pops 16-bit words from a FIFO
// and shifts them out MSB first on an active-low line, framed by active-low TransmitOn.
//
// state | meaning
// IDLE  | waiting for StartTransmit with a non-zero WordCount
// FETCH | waiting for the FIFO to hold the first word of the frame
// LOAD  | capturing the first word, clearing bit/period counters
// SHIFT | serializing; prefetches the next word during the last bit
// GAP   | forced idle so the receiver sees TransmitOn high and resets
module asic_ram_serializer #(
  parameter int BIT_PERIOD = 8,
  parameter int GAP_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        reset,
  input  logic        StartTransmit,
  input  logic [15:0] WordCount,
  input  logic [15:0] fifo_data,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic        Dout,
  output logic        TransmitOn,
  output logic        Busy,
  output logic        Done,
  output logic        Underrun
);

  localparam int PW = $clog2(BIT_PERIOD);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [PW-1:0] PCNT_LAST    = PW'(BIT_PERIOD - 1);
  localparam logic [PW-1:0] PCNT_WIN_END = PW'(BIT_PERIOD - 3);
  localparam logic [GW-1:0] GAP_LOAD     = GW'(GAP_CYCLES - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] FETCH = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] SHIFT = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;

  logic [2:0]    state;
  logic [15:0]   words_left;
  logic [15:0]   shift_reg;
  logic [15:0]   next_word;
  logic [3:0]    bit_cnt;
  logic [PW-1:0] period_cnt;
  logic [GW-1:0] gap_cnt;
  logic          pf_pending;
  logic          have_next;
  logic          in_window;
  logic          pf_rd;
  logic          starved;

  // Prefetch window ends two clocks before the wrap so the word is captured in time.
  always_comb begin
    in_window  = (state == SHIFT) && (bit_cnt == 4'd15) && (period_cnt <= PCNT_WIN_END);
    pf_rd      = in_window && (words_left != 16'd0) && !pf_pending && !have_next && !fifo_empty;
    starved    = in_window && (period_cnt == PCNT_WIN_END) && (words_left != 16'd0) &&
                 !pf_pending && !have_next && fifo_empty;
    fifo_rd_en = !reset && !fifo_empty && ((state == FETCH) || pf_rd);
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state      <= IDLE;
      words_left <= 16'd0;
      shift_reg  <= 16'd0;
      next_word  <= 16'd0;
      bit_cnt    <= 4'd0;
      period_cnt <= '0;
      gap_cnt    <= '0;
      pf_pending <= 1'b0;
      have_next  <= 1'b0;
      Dout       <= 1'b1;
      TransmitOn <= 1'b1;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Underrun   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (StartTransmit && (WordCount != 16'd0)) begin
            words_left <= WordCount;
            Underrun   <= 1'b0;
            Busy       <= 1'b1;
            state      <= FETCH;
          end
        end
        FETCH: begin
          if (!fifo_empty) state <= LOAD;
        end
        LOAD: begin
          shift_reg  <= fifo_data;
          Dout       <= ~fifo_data[15];
          TransmitOn <= 1'b0;
          words_left <= words_left - 1'b1;
          bit_cnt    <= 4'd0;
          period_cnt <= '0;
          pf_pending <= 1'b0;
          have_next  <= 1'b0;
          state      <= SHIFT;
        end
        SHIFT: begin
          if (pf_rd) pf_pending <= 1'b1;
          if (pf_pending) begin
            next_word  <= fifo_data;
            have_next  <= 1'b1;
            pf_pending <= 1'b0;
            words_left <= words_left - 1'b1;
          end
          if (starved) Underrun <= 1'b1;
          if (period_cnt == PCNT_LAST) begin
            period_cnt <= '0;
            if (bit_cnt == 4'd15) begin
              if (have_next) begin
                shift_reg <= next_word;
                Dout      <= ~next_word[15];
                bit_cnt   <= 4'd0;
                have_next <= 1'b0;
              end else begin
                TransmitOn <= 1'b1;
                Dout       <= 1'b1;
                Done       <= 1'b1;
                gap_cnt    <= GAP_LOAD;
                state      <= GAP;
              end
            end else begin
              shift_reg <= {shift_reg[14:0], 1'b0};
              Dout      <= ~shift_reg[14];
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end else begin
            period_cnt <= period_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_asic_ram_serializer.sv
// Directed bench for asic_ram_serializer: table of frames checked sample by sample,
// plus hand sequences for reset, ignored starts and reset mid-frame.
module tb_asic_ram_serializer;

  localparam int BP       = 8;
  localparam int GAP      = 16;
  localparam int WORD_CYC = 16 * BP;

  logic        Clk;
  logic        reset;
  logic        StartTransmit;
  logic [15:0] WordCount;
  logic [15:0] fifo_data;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        Dout;
  logic        TransmitOn;
  logic        Busy;
  logic        Done;
  logic        Underrun;

  asic_ram_serializer #(.BIT_PERIOD(BP), .GAP_CYCLES(GAP)) dut (
    .Clk(Clk), .reset(reset), .StartTransmit(StartTransmit), .WordCount(WordCount),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .Dout(Dout), .TransmitOn(TransmitOn), .Busy(Busy), .Done(Done), .Underrun(Underrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // FIFO model: read data appears the cycle after the strobe is sampled.
  logic [15:0] mem [0:127];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic        fifo_flush;
  assign fifo_empty = (rd_ptr == wr_ptr);

  initial fifo_data = 16'h0000;
  always @(posedge Clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (fifo_rd_en && (rd_ptr != wr_ptr)) begin
      fifo_data <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  typedef struct {
    logic [2:0][15:0] w;
    int nfifo;
    int wc;
    int exp_reads;
    int exp_low;
    int exp_und;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                              input int nf, input int wc, input int rd, input int low, input int und);
    vec_t v;
    v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
    v.nfifo = nf; v.wc = wc; v.exp_reads = rd; v.exp_low = low; v.exp_und = und;
    return v;
  endfunction

  task automatic push(input logic [15:0] d);
    mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic flush();
    @(negedge Clk) fifo_flush = 1'b1;
    @(negedge Clk) fifo_flush = 1'b0;
  endtask

  // Sample n is taken at the negedge after clock edge T+n-1 (T = start accepted).
  task automatic run_frame(input string tag, input vec_t v, input int ign1, input int ign2);
    int n = 0, first_low = -1, last_low = -1, low_cnt = 0, dout_err = 0, idle_err = 0;
    int done_cnt = 0, done_idx = -1, reads = 0, rd_bad = 0, busy_cnt = 0, busy_last = -1;
    int k, b;
    logic exp_d;
    bit fin = 0;
    for (int i = 0; i < v.nfifo; i++) push(v.w[i]);
    @(negedge Clk);
    WordCount = v.wc[15:0];
    StartTransmit = 1'b1;
    while (!fin && n < 3000) begin
      @(negedge Clk);
      n++;
      StartTransmit = (n == ign1) || (n == ign2);
      if (n == 1) check({tag, "_underrun_cleared"}, Underrun, 0);
      if (!TransmitOn) begin
        if (first_low < 0) first_low = n;
        last_low = n;
        k = low_cnt / WORD_CYC;
        b = 15 - (low_cnt % WORD_CYC) / BP;
        exp_d = (k < 3) ? ~v.w[k][b] : 1'b1;
        if (Dout !== exp_d) dout_err++;
        low_cnt++;
      end else if (Dout !== 1'b1) idle_err++;
      if (Done) begin done_cnt++; done_idx = n; end
      if (fifo_rd_en) reads++;
      if (fifo_rd_en && fifo_empty) rd_bad++;
      if (Busy) begin busy_cnt++; busy_last = n; end
      else fin = 1;
    end
    StartTransmit = 1'b0;
    check({tag, "_finished"}, int'(fin), 1);
    check({tag, "_first_bit_latency"}, first_low, 3);
    check({tag, "_low_cycles"}, low_cnt, v.exp_low);
    check({tag, "_low_continuous"}, last_low - first_low + 1, v.exp_low);
    check({tag, "_dout_errors"}, dout_err, 0);
    check({tag, "_idle_dout_errors"}, idle_err, 0);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_done_position"}, done_idx, 3 + v.exp_low);
    check({tag, "_reads"}, reads, v.exp_reads);
    check({tag, "_read_while_empty"}, rd_bad, 0);
    check({tag, "_underrun"}, Underrun, v.exp_und);
    check({tag, "_busy_cycles"}, busy_cnt, 3 + v.exp_low + GAP - 1);
    check({tag, "_busy_last"}, busy_last, 3 + v.exp_low + GAP - 1);
  endtask

  vec_t tv [5];

  initial begin
    int act, busy_seen, rd_seen, low_seen;
    tv[0] = mk(16'hA5C3, 16'h0000, 16'h0000, 1, 1, 1, 128, 0);
    tv[1] = mk(16'h1234, 16'hFFFF, 16'h0001, 3, 3, 3, 384, 0);
    tv[2] = mk(16'hBEEF, 16'h0000, 16'h0000, 1, 2, 1, 128, 1);
    tv[3] = mk(16'h8001, 16'h7FFE, 16'hC0DE, 3, 3, 3, 384, 0);
    tv[4] = mk(16'hC0DE, 16'h1111, 16'h0000, 2, 1, 1, 128, 0);

    reset = 1'b1; StartTransmit = 1'b0; WordCount = 16'd0; fifo_flush = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_dout", Dout, 1);
    check("rst_transmit_on", TransmitOn, 1);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_underrun", Underrun, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 5; i++) begin
      run_frame($sformatf("vec%0d", i), tv[i], -1, -1);
      flush();
    end

    // WordCount=0 start must be ignored even with data waiting
    push(16'h5555);
    @(negedge Clk);
    WordCount = 16'd0; StartTransmit = 1'b1;
    busy_seen = 0; rd_seen = 0; low_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      StartTransmit = 1'b0;
      if (Busy) busy_seen++;
      if (fifo_rd_en) rd_seen++;
      if (!TransmitOn) low_seen++;
    end
    check("wc0_busy", busy_seen, 0);
    check("wc0_reads", rd_seen, 0);
    check("wc0_transmit", low_seen, 0);
    flush();

    // starts pulsed during SHIFT (40) and GAP (135) must not extend the frame
    run_frame("ignored", mk(16'h5A0F, 16'h3C3C, 16'h0000, 2, 1, 1, 128, 0), 40, 135);
    flush();

    // reset 50 cycles into a frame
    push(16'hA5C3);
    @(negedge Clk);
    WordCount = 16'd1; StartTransmit = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      @(negedge Clk);
      StartTransmit = 1'b0;
    end
    reset = 1'b1;
    @(negedge Clk);
    check("midrst_dout", Dout, 1);
    check("midrst_transmit_on", TransmitOn, 1);
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    reset = 1'b0;
    act = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge Clk);
      if (Done || !TransmitOn || Busy) act++;
    end
    check("midrst_quiet_after", act, 0);
    flush();
    run_frame("after_rst", tv[0], -1, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
